// File: rtl/intu_lane_wb_queue_if.sv
// Bus between the INTU lane, the writeback queue and the register-file write port.
// The queue takes the slave view; the lane / register-file side takes the master view.
interface intu_lane_wb_queue_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 8,
    parameter int FU_W   = 3,
    parameter int DEPTH  = 4
);
    localparam int PKT_W = DATA_W + REG_W + 1 + FU_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              intuPacketLaneValid_i;
    logic [PKT_W-1:0]  intuPacketLane_i;
    logic              wbValid_o;
    logic [REG_W-1:0]  wbReg_o;
    logic [DATA_W-1:0] wbData_o;
    logic [FU_W-1:0]   wbFU_o;
    logic              wbGrant_i;
    logic              intuStall_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;

    modport slave (
        input  intuPacketLaneValid_i,
        input  intuPacketLane_i,
        input  wbGrant_i,
        output wbValid_o,
        output wbReg_o,
        output wbData_o,
        output wbFU_o,
        output intuStall_o,
        output count_o,
        output overflow_o
    );

    modport master (
        output intuPacketLaneValid_i,
        output intuPacketLane_i,
        output wbGrant_i,
        input  wbValid_o,
        input  wbReg_o,
        input  wbData_o,
        input  wbFU_o,
        input  intuStall_o,
        input  count_o,
        input  overflow_o
    );
endinterface

// File: rtl/intu_lane_wb_queue.sv
// Per-lane writeback FIFO behind the INTU lane: buffers result packets, drains one per
// register-file grant, and stalls issue early because the lane itself cannot be stalled.
module intu_lane_wb_queue #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 8,
    parameter int FU_W         = 3,
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    intu_lane_wb_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + REG_W + FU_W;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(STALL_MARGIN);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("intu_lane_wb_queue: DEPTH must be a power of two >= 2");
    end
    if (STALL_MARGIN < 1 || STALL_MARGIN >= DEPTH) begin : g_bad_margin
        $error("intu_lane_wb_queue: STALL_MARGIN must satisfy 1 <= STALL_MARGIN < DEPTH");
    end

    logic [DATA_W-1:0] pkt_data;
    logic [REG_W-1:0]  pkt_reg;
    logic              pkt_dv;
    logic [FU_W-1:0]   pkt_fu;

    assign {pkt_data, pkt_reg, pkt_dv, pkt_fu} = bus.intuPacketLane_i;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic             ovf_q, ovf_d;

    logic push, pop, head_vld, full, wr_en, drop;

    always_comb begin
        push     = bus.intuPacketLaneValid_i & pkt_dv;
        head_vld = (count_q != '0);
        pop      = head_vld & bus.wbGrant_i;
        full     = (count_q == DEPTH_C);
        // A pop in the same cycle frees the slot, so a full queue still accepts the push.
        wr_en    = push & (~full | pop);
        drop     = push & full & ~pop;

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ovf_d   = ovf_q | drop;
        // Stall looks at next-cycle occupancy so in-flight issues always find a slot.
        stall_d = (DEPTH_C - count_d) < MARGIN_C;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {pkt_data, pkt_reg, pkt_fu};
        end
    end

    logic [ENT_W-1:0] head;
    assign head = mem_q[rd_ptr_q];

    assign bus.wbValid_o   = head_vld;
    assign bus.wbData_o    = head_vld ? head[ENT_W-1 -: DATA_W]     : '0;
    assign bus.wbReg_o     = head_vld ? head[FU_W +: REG_W]         : '0;
    assign bus.wbFU_o      = head_vld ? head[FU_W-1:0]              : '0;
    assign bus.intuStall_o = stall_q;
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = ovf_q;

endmodule

// File: tb/tb_intu_lane_wb_queue.sv
// Self-checking bench for intu_lane_wb_queue: directed vector table, hand-written
// overflow / async-reset sequences, and randomized traffic against a queue model.
module tb_intu_lane_wb_queue;
    localparam int DATA_W = 32;
    localparam int REG_W  = 8;
    localparam int FU_W   = 3;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    intu_lane_wb_queue_if #(.DATA_W(DATA_W), .REG_W(REG_W), .FU_W(FU_W), .DEPTH(DEPTH)) bus ();

    intu_lane_wb_queue #(
        .DATA_W(DATA_W), .REG_W(REG_W), .FU_W(FU_W), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] r,
                         input logic dv, input logic [2:0] fu, input logic g);
        bus.intuPacketLaneValid_i = v;
        bus.intuPacketLane_i      = {d, r, dv, fu};
        bus.wbGrant_i             = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain queue of accepted packets plus sticky overflow flag.
    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  r;
        logic [2:0]  fu;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    bit   m_stall;

    task automatic model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 3'h0, 1'b0);
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic check_model(input string tag);
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".valid"}, bus.wbValid_o,  mq.size() != 0);
        chk({tag, ".data"},  bus.wbData_o,   h.d);
        chk({tag, ".reg"},   bus.wbReg_o,    h.r);
        chk({tag, ".fu"},    bus.wbFU_o,     h.fu);
        chk({tag, ".count"}, bus.count_o,    mq.size());
        chk({tag, ".stall"}, bus.intuStall_o, m_stall);
        chk({tag, ".ovf"},   bus.overflow_o, m_ovf);
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic [7:0] r, input logic dv, input logic [2:0] fu,
                        input logic g);
        int   sz;
        bit   do_push, do_pop;
        ent_t e;
        drive(v, d, r, dv, fu, g);
        sz      = mq.size();
        do_push = v && dv;
        do_pop  = (sz != 0) && g;
        e.d = d; e.r = r; e.fu = fu;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (sz == DEPTH && !do_pop) m_ovf = 1'b1;
            else mq.push_back(e);
        end
        m_stall = (DEPTH - mq.size()) < MARGIN;
        tick();
        check_model(tag);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [7:0]  r;
        logic        dv;
        logic [2:0]  fu;
        logic        g;
        logic        ev;
        logic [7:0]  er;
        logic [31:0] ed;
        logic [2:0]  efu;
        logic [2:0]  ec;
        logic        es;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [31:0] d, logic [7:0] r, logic dv,
                                logic [2:0] fu, logic g, logic ev, logic [7:0] er,
                                logic [31:0] ed, logic [2:0] efu, logic [2:0] ec,
                                logic es, logic eo);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.dv = dv; t.fu = fu; t.g = g;
        t.ev = ev; t.er = er; t.ed = ed; t.efu = efu; t.ec = ec; t.es = es; t.eo = eo;
        return t;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                v  data          reg dv fu g   ev er data          fu cnt st ov
        vecs.push_back(mk(1, 32'h0000_1234, 5, 1, 2, 1,  1, 5, 32'h0000_1234, 2, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 0, 1,  0, 0, 32'h0,         0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0101, 1, 1, 1, 0,  1, 1, 32'h0000_0101, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0102, 2, 1, 2, 0,  1, 1, 32'h0000_0101, 1, 2, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0103, 3, 1, 3, 0,  1, 1, 32'h0000_0101, 1, 3, 1, 0));
        vecs.push_back(mk(1, 32'h0000_0104, 4, 1, 4, 0,  1, 1, 32'h0000_0101, 1, 4, 1, 0));
        vecs.push_back(mk(1, 32'h0000_00AA, 6, 1, 5, 1,  1, 2, 32'h0000_0102, 2, 4, 1, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 0, 1,  1, 3, 32'h0000_0103, 3, 3, 1, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 0, 1,  1, 4, 32'h0000_0104, 4, 2, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 0, 1,  1, 6, 32'h0000_00AA, 5, 1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0055, 7, 0, 1, 0,  1, 6, 32'h0000_00AA, 5, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 0, 1,  0, 0, 32'h0,         0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0077, 9, 0, 3, 1,  0, 0, 32'h0,         0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 0, 1,  0, 0, 32'h0,         0, 0, 0, 0));

        reset = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 3'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", bus.wbValid_o, 0);
        chk("rst.data",  bus.wbData_o, 0);
        chk("rst.reg",   bus.wbReg_o, 0);
        chk("rst.fu",    bus.wbFU_o, 0);
        chk("rst.count", bus.count_o, 0);
        chk("rst.stall", bus.intuStall_o, 0);
        chk("rst.ovf",   bus.overflow_o, 0);
        reset = 1'b0;
        model_clear();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].dv, vecs[i].fu, vecs[i].g);
            tick();
            chk($sformatf("vec%0d.valid", i), bus.wbValid_o,   vecs[i].ev);
            chk($sformatf("vec%0d.reg", i),   bus.wbReg_o,     vecs[i].er);
            chk($sformatf("vec%0d.data", i),  bus.wbData_o,    vecs[i].ed);
            chk($sformatf("vec%0d.fu", i),    bus.wbFU_o,      vecs[i].efu);
            chk($sformatf("vec%0d.count", i), bus.count_o,     vecs[i].ec);
            chk($sformatf("vec%0d.stall", i), bus.intuStall_o, vecs[i].es);
            chk($sformatf("vec%0d.ovf", i),   bus.overflow_o,  vecs[i].eo);
        end

        // Overflow on a full queue: dropped packet, sticky flag, head untouched.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + k, 8'(k + 1), 1'b1, 3'(k), 1'b0);
            tick();
        end
        drive(1'b1, 32'hDEAD_BEEF, 8'd9, 1'b1, 3'd7, 1'b0);
        tick();
        chk("ovf.flag",  bus.overflow_o, 1);
        chk("ovf.count", bus.count_o, 4);
        chk("ovf.head",  bus.wbData_o, 32'h200);
        chk("ovf.reg",   bus.wbReg_o, 1);
        drive(1'b0, 32'h0, 8'h0, 1'b0, 3'h0, 1'b0);
        tick();
        tick();
        chk("ovf.sticky", bus.overflow_o, 1);
        drive(1'b0, 32'h0, 8'h0, 1'b0, 3'h0, 1'b1);
        tick();
        chk("ovf.after_pop",  bus.overflow_o, 1);
        chk("ovf.pop_count",  bus.count_o, 3);
        chk("ovf.pop_head",   bus.wbData_o, 32'h201);
        do_reset();
        chk("ovf.cleared", bus.overflow_o, 0);
        chk("ovf.cleared_count", bus.count_o, 0);

        // Pointer wrap: ten push+pop pairs with one entry kept in flight.
        do_reset();
        step("wrap.prime", 1'b1, 32'h3000, 8'd1, 1'b1, 3'd1, 1'b0);
        for (int k = 1; k <= 10; k++)
            step($sformatf("wrap%0d", k), 1'b1, 32'h3000 + k, 8'(k + 1), 1'b1, 3'(k), 1'b1);
        chk("wrap.last_head", bus.wbData_o, 32'h300A);

        // Asynchronous reset with three entries queued clears outputs before the next edge.
        step("ar.push0", 1'b1, 32'h4000, 8'd20, 1'b1, 3'd1, 1'b0);
        step("ar.push1", 1'b1, 32'h4001, 8'd21, 1'b1, 3'd2, 1'b0);
        drive(1'b0, 32'h0, 8'h0, 1'b0, 3'h0, 1'b0);
        tick();
        chk("ar.count_before", bus.count_o, 3);
        chk("ar.stall_before", bus.intuStall_o, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.valid", bus.wbValid_o, 0);
        chk("ar.data",  bus.wbData_o, 0);
        chk("ar.reg",   bus.wbReg_o, 0);
        chk("ar.fu",    bus.wbFU_o, 0);
        chk("ar.count", bus.count_o, 0);
        chk("ar.stall", bus.intuStall_o, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step("ar.after", 1'b0, 32'h0, 8'h0, 1'b0, 3'h0, 1'b1);

        // Randomized traffic alternating between filling and draining phases.
        for (int i = 0; i < 400; i++) begin
            logic g;
            g = ((i % 80) < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom,
                 8'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
